// File: rtl/clkgen_pkg.sv
// Shared types and constants for the 8085 front-end clock/reset generator.
// Optional READY synchroniser is enabled with CLKGEN_READY_SYNC_EN.
package clkgen_pkg;

    localparam int unsigned TSTATE_X1_CYCLES = 4;
    localparam int unsigned TSTATE_CNT_W     = 8;

    typedef enum logic [$clog2(TSTATE_X1_CYCLES)-1:0] {
        PH_PHI1 = 2'd0,
        PH_GAP1 = 2'd1,
        PH_PHI2 = 2'd2,
        PH_GAP2 = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t cur);
        phase_t nxt;
        case (cur)
            PH_PHI1: nxt = PH_GAP1;
            PH_GAP1: nxt = PH_PHI2;
            PH_PHI2: nxt = PH_GAP2;
            default: nxt = PH_PHI1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/clock_reset_gen_reset_stretch.sv
// Saturating T-state counter that holds reset/reset_out high for RESET_TSTATES
// complete T-states after board reset releases, releasing on a T-state start.
module reset_stretch
    import clkgen_pkg::*;
#(
    parameter int unsigned RESET_TSTATES = 3
) (
    input  logic x1,
    input  logic resetn_in,
    input  logic tstate_end,
    input  logic tstate_start,
    output logic reset,
    output logic reset_out
);

    localparam logic [TSTATE_CNT_W-1:0] TARGET = RESET_TSTATES[TSTATE_CNT_W-1:0];

    logic [TSTATE_CNT_W-1:0] tstate_cnt;
    logic [TSTATE_CNT_W-1:0] cnt_next;
    logic                    done_next;

    // Counting stops at the target, so 255 never wraps back to 0.
    always_comb begin
        cnt_next = tstate_cnt;
        if (tstate_end && (tstate_cnt < TARGET)) begin
            cnt_next = tstate_cnt + 1'b1;
        end
        done_next = (cnt_next == TARGET);
    end

    always_ff @(posedge x1) begin
        if (!resetn_in) begin
            tstate_cnt <= '0;
            reset      <= 1'b1;
            reset_out  <= 1'b1;
        end else begin
            tstate_cnt <= cnt_next;
            if (tstate_start && done_next) begin
                reset     <= 1'b0;
                reset_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_reset_gen.sv
// Two-phase 8085 clock generator (x1/4) with T-state aligned reset stretch.
// Define CLKGEN_READY_SYNC_EN to add the ready_in -> ready_sync synchroniser.
module clock_reset_gen
    import clkgen_pkg::*;
#(
    parameter int unsigned RESET_TSTATES = 3
) (
    input  logic x1,
    input  logic resetn_in,
    output logic phi1,
    output logic phi2,
    output logic clk_out,
    output logic reset,
    output logic reset_out
`ifdef CLKGEN_READY_SYNC_EN
    ,
    input  logic ready_in,
    output logic ready_sync
`endif
);

    phase_t phase;
    phase_t phase_nxt;
    logic   tstate_end;
    logic   tstate_start;

    always_comb begin
        phase_nxt = next_phase(phase);
    end

    // Outputs are registered from the next phase so they change on the same
    // edge as the phase register itself.
    always_ff @(posedge x1) begin
        if (!resetn_in) begin
            phase   <= PH_GAP2;
            phi1    <= 1'b0;
            phi2    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            phi1    <= (phase_nxt == PH_PHI1);
            phi2    <= (phase_nxt == PH_PHI2);
            clk_out <= (phase_nxt == PH_PHI2) || (phase_nxt == PH_GAP2);
        end
    end

    // The GAP2 held during reset is not a completed T-state; clk_out is only
    // high in GAP2 once a real T-state has run, so it qualifies the strobe.
    assign tstate_end   = (phase == PH_GAP2) && clk_out;
    assign tstate_start = (phase_nxt == PH_PHI1);

    reset_stretch #(
        .RESET_TSTATES(RESET_TSTATES)
    ) u_reset_stretch (
        .x1          (x1),
        .resetn_in   (resetn_in),
        .tstate_end  (tstate_end),
        .tstate_start(tstate_start),
        .reset       (reset),
        .reset_out   (reset_out)
    );

`ifdef CLKGEN_READY_SYNC_EN
    logic ready_meta;

    always_ff @(posedge x1) begin
        if (!resetn_in) begin
            ready_meta <= 1'b0;
            ready_sync <= 1'b0;
        end else begin
            ready_meta <= ready_in;
            if (reset) begin
                ready_sync <= 1'b0;
            end else if (phase_nxt == PH_PHI2) begin
                ready_sync <= ready_meta;
            end
        end
    end
`endif

endmodule
